// File: rtl/latch_bank_wr_ctrl_if.sv
// -----------------------------------------------------------------------------
// latch_bank_wr_ctrl_if
//   Requester-side request bus plus the latch-array drive signals of
//   latch_bank_wr_ctrl. The controller attaches through the slave modport;
//   requester logic (or a testbench) uses the master modport.
// -----------------------------------------------------------------------------
interface latch_bank_wr_ctrl_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 2
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      ack;
  logic [(1<<AW)-1:0]   lat_en;
  logic [DW-1:0]        lat_d;
  logic                 busy;
  logic [GW-1:0]        grant_id;

  modport master (
    output req, req_addr, req_data,
    input  ack, lat_en, lat_d, busy, grant_id
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, lat_en, lat_d, busy, grant_id
  );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_wr_ctrl
//   Write sequencer for an external bank of level-sensitive D-latches shared
//   by NREQ requesters. Each write runs SETUP (data driven, enables low),
//   OPEN (one enable high for OPEN_CYC cycles) and HOLD (enables low, data
//   still held, ack pulsed) so latch data is stable around both enable edges.
//
//   Optional build macro: LATCH_ARB_FIXED_PRIO_EN
//     undefined (default) : round-robin arbitration with a rotating pointer
//     defined             : fixed priority, lowest requester index wins,
//                           no pointer is built
//   Phase timing and handshake are identical in both builds.
//
//   Reset is synchronous and active-low; every output is a flop.
// -----------------------------------------------------------------------------
module latch_bank_wr_ctrl #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int OPEN_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  latch_bank_wr_ctrl_if.slave   bus
);

  localparam int DEPTH = 1 << AW;
  localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_CYC - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   addr_r;
  logic [CW-1:0]   open_cnt_r;

  logic            win_found_s;
  logic [GW-1:0]   win_idx_s;
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_data_s;

  // One-hot latch enable for a bank entry.
  function automatic logic [DEPTH-1:0] entry_onehot(input logic [AW-1:0] a);
    logic [DEPTH-1:0] v;
    v    = {DEPTH{1'b0}};
    v[a] = 1'b1;
    return v;
  endfunction

  // One-hot ack vector for a requester index.
  function automatic logic [NREQ-1:0] req_onehot(input logic [GW-1:0] g);
    logic [NREQ-1:0] v;
    v    = {NREQ{1'b0}};
    v[g] = 1'b1;
    return v;
  endfunction

`ifdef LATCH_ARB_FIXED_PRIO_EN

  // Fixed priority: scan from the top so the lowest set index is left last.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {GW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_found_s = 1'b1;
        win_idx_s   = GW'(i);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

`else

  logic [GW-1:0] ptr_r;

  // Round-robin pick: rotate the request vector so the pointer position is
  // bit 0, take the first set bit, then map it back to a requester index.
  function automatic logic [GW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [GW-1:0]   p);
    logic [2*NREQ-1:0] dbl;
    logic              found;
    logic [GW:0]       sum;
    logic [GW-1:0]     idx;
    dbl   = {r, r} >> p;
    found = 1'b0;
    idx   = {GW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, p} + (GW+1)'(k);
      if (sum >= (GW+1)'(NREQ)) begin
        sum = sum - (GW+1)'(NREQ);
      end else begin
        sum = sum;
      end
      if (!found && dbl[k]) begin
        found = 1'b1;
        idx   = sum[GW-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Round-robin winner search starting at the pointer.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {GW{1'b0}};
    {win_found_s, win_idx_s} = rr_pick(bus.req, ptr_r);
  end

  // Pointer moves past the winner when its write completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= {GW{1'b0}};
    end else if (state_r == ST_OPEN && open_cnt_r == OPEN_LAST) begin
      ptr_r <= (bus.grant_id == LAST_REQ) ? {GW{1'b0}} : bus.grant_id + GW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

`endif

  // Select the winning requester's address and data from the packed buses.
  always_comb begin
    win_addr_s = {AW{1'b0}};
    win_data_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_s == GW'(i)) begin
        win_addr_s = bus.req_addr[i*AW +: AW];
        win_data_s = bus.req_data[i*DW +: DW];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  // Transaction sequencer: IDLE -> SETUP -> OPEN x OPEN_CYC -> HOLD -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= {AW{1'b0}};
      open_cnt_r   <= {CW{1'b0}};
      bus.lat_en   <= {DEPTH{1'b0}};
      bus.lat_d    <= {DW{1'b0}};
      bus.ack      <= {NREQ{1'b0}};
      bus.busy     <= 1'b0;
      bus.grant_id <= {GW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus.ack    <= {NREQ{1'b0}};
          bus.lat_en <= {DEPTH{1'b0}};
          open_cnt_r <= {CW{1'b0}};
          if (win_found_s) begin
            // lat_d only ever changes here, on the way into SETUP.
            state_r      <= ST_SETUP;
            bus.busy     <= 1'b1;
            bus.grant_id <= win_idx_s;
            addr_r       <= win_addr_s;
            bus.lat_d    <= win_data_s;
          end else begin
            state_r  <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_r    <= ST_OPEN;
          open_cnt_r <= {CW{1'b0}};
          bus.lat_en <= entry_onehot(addr_r);
        end
        ST_OPEN: begin
          if (open_cnt_r == OPEN_LAST) begin
            state_r    <= ST_HOLD;
            open_cnt_r <= {CW{1'b0}};
            bus.lat_en <= {DEPTH{1'b0}};
            bus.ack    <= req_onehot(bus.grant_id);
          end else begin
            open_cnt_r <= open_cnt_r + CW'(1);
          end
        end
        ST_HOLD: begin
          state_r  <= ST_IDLE;
          bus.ack  <= {NREQ{1'b0}};
          bus.busy <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          open_cnt_r <= {CW{1'b0}};
          bus.lat_en <= {DEPTH{1'b0}};
          bus.ack    <= {NREQ{1'b0}};
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_wr_ctrl
//   Directed steps followed by randomized traffic. Expected outputs come from
//   a transaction-level model: each granted write is a timeline of
//   OPEN_CYC+2 cycles after capture, and the winner is chosen by scanning the
//   request vector from the pointer (or from index 0 with
//   LATCH_ARB_FIXED_PRIO_EN).
// -----------------------------------------------------------------------------
module tb_latch_bank_wr_ctrl;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int AW       = 2;
  localparam int OPEN_CYC = 2;
  localparam int DEPTH    = 1 << AW;

  logic clk;
  logic rst_n;

  logic [NREQ-1:0] req_v;
  logic [AW-1:0]   addr_v [NREQ];
  logic [DW-1:0]   data_v [NREQ];

  latch_bank_wr_ctrl_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

  latch_bank_wr_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .OPEN_CYC(OPEN_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req = req_v;

  // Pack per-requester address/data onto the flat buses.
  always_comb begin
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW] = addr_v[i];
      bus.req_data[i*DW +: DW] = data_v[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state
  int            m_p;      // 0 = idle, 1..OPEN_CYC+2 = cycles since capture
  int            m_ptr;
  int            m_gid;
  int            m_addr;
  logic [DW-1:0] m_latd;

  logic [DEPTH-1:0] e_laten;
  logic [NREQ-1:0]  e_ack;
  logic             e_busy;

  int ack_q[$];
  int ack_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner(input logic [NREQ-1:0] r, input int ptr);
`ifdef LATCH_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
    return 0;
  endfunction

  // Advance one clock, update the model, compare every output.
  task automatic tick();
    int w;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      m_p = 0; m_ptr = 0; m_gid = 0; m_addr = 0; m_latd = '0;
    end else if (m_p == 0) begin
      if (req_v != '0) begin
        w      = pick_winner(req_v, m_ptr);
        m_p    = 1;
        m_gid  = w;
        m_addr = int'(addr_v[w]);
        m_latd = data_v[w];
        m_ptr  = (w + 1) % NREQ;
      end
    end else if (m_p == OPEN_CYC + 2) begin
      m_p = 0;
    end else begin
      m_p = m_p + 1;
    end
    e_busy  = (m_p != 0);
    e_laten = '0;
    if (m_p >= 2 && m_p <= OPEN_CYC + 1) e_laten[m_addr] = 1'b1;
    e_ack = '0;
    if (m_p == OPEN_CYC + 2) e_ack[m_gid] = 1'b1;
    chk("lat_en",   32'(bus.lat_en),   32'(e_laten));
    chk("lat_d",    32'(bus.lat_d),    32'(m_latd));
    chk("ack",      32'(bus.ack),      32'(e_ack));
    chk("busy",     32'(bus.busy),     32'(e_busy));
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i] === 1'b1) begin
        ack_q.push_back(i);
        ack_cyc_q.push_back(cyc);
      end
    end
  endtask

  // Run until n acks have been seen; requesters drop (or re-request with new data).
  task automatic run_acks(input int n, input bit keep, input int budget);
    int b;
    b = budget;
    while (ack_q.size() < n && b > 0) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (e_ack[i]) begin
          if (keep) data_v[i] = DW'($urandom);
          else      req_v[i] = 1'b0;
        end
      end
      b--;
    end
    chk("ack_count", 32'(ack_q.size()), 32'(n));
  endtask

  int exp_t4 [4];

  initial begin
    rst_n = 1'b0;
    req_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr_v[i] = AW'(i);
      data_v[i] = DW'(8'h10 + i);
    end

    // Test 1: reset held 3 cycles with all requests high.
    req_v = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_lat_en", 32'(bus.lat_en), 32'h0);
      chk("t1_busy",   32'(bus.busy),   32'h0);
    end
    rst_n = 1'b1;

    // Test 3: all four requesting, each drops after its ack -> 0,1,2,3, 5 cycles apart.
    ack_q.delete(); ack_cyc_q.delete();
    run_acks(4, 1'b0, 40);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_q.size()) chk("t3_order", 32'(ack_q[k]), 32'(k));
      if (k > 0 && k < ack_cyc_q.size())
        chk("t3_spacing", 32'(ack_cyc_q[k] - ack_cyc_q[k-1]), 32'(OPEN_CYC + 3));
    end
    tick();

    // Test 2: single write req0, addr 2, data 0xA5.
    req_v = 4'b0001; addr_v[0] = 2'd2; data_v[0] = 8'hA5;
    tick();
    chk("t2_setup_lat_d",  32'(bus.lat_d),  32'hA5);
    chk("t2_setup_lat_en", 32'(bus.lat_en), 32'h0);
    tick();
    chk("t2_open1_lat_en", 32'(bus.lat_en), 32'b0100);
    tick();
    chk("t2_open2_lat_en", 32'(bus.lat_en), 32'b0100);
    tick();
    chk("t2_hold_lat_en",  32'(bus.lat_en), 32'h0);
    chk("t2_hold_ack",     32'(bus.ack),    32'b0001);
    req_v = '0;
    tick();
    chk("t2_idle_busy",    32'(bus.busy),   32'h0);

    // Test 4: req0 and req2 re-requesting continuously (pointer now 1).
`ifdef LATCH_ARB_FIXED_PRIO_EN
    exp_t4 = '{0, 0, 0, 0};
`else
    exp_t4 = '{2, 0, 2, 0};
`endif
    ack_q.delete(); ack_cyc_q.delete();
    req_v = 4'b0101;
    run_acks(4, 1'b1, 40);
    for (int k = 0; k < 4 && k < ack_q.size(); k++) chk("t4_order", 32'(ack_q[k]), 32'(exp_t4[k]));
    req_v = '0;
    tick();

    // Test 5: reset for one edge during OPEN.
    req_v = 4'b0010; addr_v[1] = 2'd3; data_v[1] = 8'h5A;
    tick();
    tick();
    chk("t5_open_lat_en", 32'(bus.lat_en), 32'b1000);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_lat_en", 32'(bus.lat_en), 32'h0);
    chk("t5_rst_ack",    32'(bus.ack),    32'h0);
    chk("t5_rst_busy",   32'(bus.busy),   32'h0);
    chk("t5_rst_lat_d",  32'(bus.lat_d),  32'h0);
    rst_n = 1'b1;
    req_v = 4'b1111;
    tick();
    chk("t5_ptr_reset_grant", 32'(bus.grant_id), 32'h0);
    ack_q.delete(); ack_cyc_q.delete();
    run_acks(4, 1'b0, 40);
    tick();

    // Test 6: data change during OPEN is ignored.
    req_v = 4'b1000; addr_v[3] = 2'd1; data_v[3] = 8'h3C;
    tick();
    chk("t6_setup_lat_d", 32'(bus.lat_d), 32'h3C);
    tick();
    data_v[3] = 8'hFF;
    tick();
    chk("t6_open_lat_d", 32'(bus.lat_d), 32'h3C);
    tick();
    chk("t6_hold_lat_d", 32'(bus.lat_d), 32'h3C);
    chk("t6_hold_ack",   32'(bus.ack),   32'b1000);
    req_v = '0;
    tick();
    chk("t6_idle_lat_d", 32'(bus.lat_d), 32'h3C);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      tick();
      rst_n = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            req_v[i] = 1'b0;
          end else begin
            addr_v[i] = AW'($urandom);
            data_v[i] = DW'($urandom);
          end
        end else if (!req_v[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_v[i]  = 1'b1;
            addr_v[i] = AW'($urandom);
            data_v[i] = DW'($urandom);
          end
        end else if (m_p != 0 && m_gid == i) begin
          if ($urandom_range(0, 1) == 0) begin
            addr_v[i] = AW'($urandom);
            data_v[i] = DW'($urandom);
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
